// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: turns hazard-unit requests into pipeline register load/valid controls with perf counters
module pipeline_stall_ctrl #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_req,
    input  logic                 load_use_stall,
    input  logic                 icache_stall,
    input  logic                 dcache_stall,
    output logic                 pc_load,
    output logic                 if_id_load,
    output logic                 id_ex_load,
    output logic                 ex_mem_load,
    output logic                 mem_wb_load,
    output logic                 if_id_valid_in,
    output logic                 id_ex_valid_in,
    output logic                 ex_mem_valid_in,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt,
    output logic [CNT_WIDTH-1:0] bubble_cnt
);
    typedef enum logic [1:0] {RUN, FROZEN, BUBBLE} state_t;

    state_t               state_q, state_d;
    logic                 flush_pend_q, flush_pend_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_WIDTH-1:0] bubble_cnt_q, bubble_cnt_d;
    logic                 freeze, lu_take, flush_take;

    // Decide this cycle's action (freeze > load-use > flush > normal) and the next state/counters
    always_comb begin
        freeze       = icache_stall | dcache_stall;
        lu_take      = !freeze && state_q != BUBBLE && load_use_stall;
        flush_take   = !freeze && !lu_take && (flush_req || flush_pend_q);
        state_d      = freeze ? FROZEN : lu_take ? BUBBLE : RUN;
        flush_pend_d = flush_take ? 1'b0 : (flush_pend_q | flush_req);
        stall_cnt_d  = (freeze && stall_cnt_q != '1) ? stall_cnt_q + CNT_WIDTH'(1) : stall_cnt_q;
        flush_cnt_d  = (flush_take && flush_cnt_q != '1) ? flush_cnt_q + CNT_WIDTH'(1) : flush_cnt_q;
        bubble_cnt_d = (lu_take && bubble_cnt_q != '1) ? bubble_cnt_q + CNT_WIDTH'(1) : bubble_cnt_q;
    end

    // Load enables and valid bits respond in the same cycle; everything is held off while in reset
    always_comb begin
        pc_load         = !rst && !freeze && !lu_take;
        if_id_load      = !rst && !freeze && !lu_take;
        id_ex_load      = !rst && !freeze && !lu_take;
        ex_mem_load     = !rst && !freeze;
        mem_wb_load     = !rst && !freeze;
        if_id_valid_in  = !rst && !flush_take;
        id_ex_valid_in  = !rst && !flush_take;
        ex_mem_valid_in = !rst && !lu_take;
        stall_cnt       = stall_cnt_q;
        flush_cnt       = flush_cnt_q;
        bubble_cnt      = bubble_cnt_q;
    end

    // State, sticky flush and counters; reset discards any pending flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            flush_pend_q <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed and random checks of pipeline_stall_ctrl against a behavioural model
module tb_pipeline_stall_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush_req = 1'b0, load_use_stall = 1'b0, icache_stall = 1'b0, dcache_stall = 1'b0;
    logic pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
    logic if_id_valid_in, id_ex_valid_in, ex_mem_valid_in;
    logic [31:0] stall_cnt, flush_cnt, bubble_cnt;
    logic s_pc_load, s_if_id_load, s_id_ex_load, s_ex_mem_load, s_mem_wb_load;
    logic s_if_id_valid_in, s_id_ex_valid_in, s_ex_mem_valid_in;
    logic [3:0] s_stall_cnt, s_flush_cnt, s_bubble_cnt;
    int tests = 0;
    int fails = 0;

    // model state: was last cycle a bubble, pending flush, unbounded event counts
    bit m_prev_bubble = 0;
    bit m_pend = 0;
    longint m_stall = 0, m_flush = 0, m_bubble = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush_req(flush_req), .load_use_stall(load_use_stall),
        .icache_stall(icache_stall), .dcache_stall(dcache_stall),
        .pc_load(pc_load), .if_id_load(if_id_load), .id_ex_load(id_ex_load),
        .ex_mem_load(ex_mem_load), .mem_wb_load(mem_wb_load),
        .if_id_valid_in(if_id_valid_in), .id_ex_valid_in(id_ex_valid_in), .ex_mem_valid_in(ex_mem_valid_in),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .bubble_cnt(bubble_cnt)
    );

    pipeline_stall_ctrl #(.CNT_WIDTH(4)) dut_small (
        .clk(clk), .rst(rst), .flush_req(flush_req), .load_use_stall(load_use_stall),
        .icache_stall(icache_stall), .dcache_stall(dcache_stall),
        .pc_load(s_pc_load), .if_id_load(s_if_id_load), .id_ex_load(s_id_ex_load),
        .ex_mem_load(s_ex_mem_load), .mem_wb_load(s_mem_wb_load),
        .if_id_valid_in(s_if_id_valid_in), .id_ex_valid_in(s_id_ex_valid_in), .ex_mem_valid_in(s_ex_mem_valid_in),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .bubble_cnt(s_bubble_cnt)
    );

    wire [7:0] pack = {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
                       if_id_valid_in, id_ex_valid_in, ex_mem_valid_in};
    wire [7:0] s_pack = {s_pc_load, s_if_id_load, s_id_ex_load, s_ex_mem_load, s_mem_wb_load,
                         s_if_id_valid_in, s_id_ex_valid_in, s_ex_mem_valid_in};

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint mx = (longint'(1) << w) - 1;
        return v > mx ? mx : v;
    endfunction

    // compare process: every negedge, check both instances against the model, then advance the model
    always @(negedge clk) begin
        bit fz, lu, fl;
        logic [7:0] e;
        if (rst) begin
            m_prev_bubble = 0;
            m_pend = 0;
            m_stall = 0;
            m_flush = 0;
            m_bubble = 0;
            e = 8'h00;
        end else begin
            fz = icache_stall || dcache_stall;
            lu = !fz && !m_prev_bubble && load_use_stall;
            fl = !fz && !lu && (flush_req || m_pend);
            e = fz ? 8'h07 : lu ? 8'h1E : fl ? 8'hF9 : 8'hFF;
        end
        chk("ctrl", pack, e);
        chk("ctrl_small", s_pack, e);
        chk("stall_cnt", stall_cnt, sat(m_stall, 32));
        chk("flush_cnt", flush_cnt, sat(m_flush, 32));
        chk("bubble_cnt", bubble_cnt, sat(m_bubble, 32));
        chk("stall_cnt4", s_stall_cnt, sat(m_stall, 4));
        chk("flush_cnt4", s_flush_cnt, sat(m_flush, 4));
        chk("bubble_cnt4", s_bubble_cnt, sat(m_bubble, 4));
        if (!rst) begin
            m_prev_bubble = lu;
            m_pend = fl ? 1'b0 : (m_pend | flush_req);
            m_stall += fz;
            m_flush += fl;
            m_bubble += lu;
        end
    end

    // drive one cycle's requests just after the edge; return with outputs settled
    task automatic cyc(input logic fr, input logic lu, input logic ic, input logic dc);
        @(posedge clk);
        #1;
        flush_req = fr;
        load_use_stall = lu;
        icache_stall = ic;
        dcache_stall = dc;
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        chk("reset_ctrl", pack, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(0, 0, 0, 0);
        chk("t1_ctrl", pack, 8'hFF);
        chk("t1_cnt", stall_cnt + flush_cnt + bubble_cnt, 0);
        repeat (3) begin
            cyc(0, 0, 1, 0);
            chk("t2_frozen", pack, 8'h07);
        end
        cyc(0, 0, 0, 0);
        chk("t2_ctrl", pack, 8'hFF);
        chk("t2_stall_cnt", stall_cnt, 3);
        cyc(0, 1, 0, 0);
        chk("t3_bubble", pack, 8'h1E);
        cyc(0, 1, 0, 0);
        chk("t3_no_second", pack, 8'hFF);
        chk("t3_bubble_cnt", bubble_cnt, 1);
        cyc(1, 0, 0, 1);
        chk("t4_frozen", pack, 8'h07);
        repeat (3) cyc(0, 0, 0, 1);
        chk("t4_frozen_late", pack, 8'h07);
        cyc(0, 0, 0, 0);
        chk("t4_flush", pack, 8'hF9);
        cyc(0, 0, 0, 0);
        chk("t4_after", pack, 8'hFF);
        chk("t4_flush_cnt", flush_cnt, 1);
        chk("t4_stall_cnt", stall_cnt, 7);
        cyc(1, 1, 0, 0);
        chk("t5_bubble", pack, 8'h1E);
        cyc(0, 0, 0, 0);
        chk("t5_flush", pack, 8'hF9);
        cyc(0, 0, 0, 0);
        chk("t5_after", pack, 8'hFF);
        chk("t5_bubble_cnt", bubble_cnt, 2);
        chk("t5_flush_cnt", flush_cnt, 2);
        repeat (20) cyc(0, 0, 1, 0);
        cyc(1, 0, 1, 0);
        chk("t6_stall_cnt", stall_cnt, 27);
        chk("t6_stall_sat", s_stall_cnt, 15);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_rst_cnt", stall_cnt, 0);
        chk("t6_rst_cnt4", s_stall_cnt, 0);
        chk("t6_rst_ctrl", pack, 8'h00);
        icache_stall = 1'b0;
        flush_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(0, 0, 0, 0);
        chk("t6_pend_dropped", pack, 8'hFF);
        chk("t6_flush_cnt", flush_cnt, 0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(149) == 0) begin
                @(posedge clk);
                #3;
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end else begin
                cyc($urandom_range(4) == 0, $urandom_range(3) == 0,
                    $urandom_range(4) == 0, $urandom_range(5) == 0);
            end
        end
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
